geo_cmd_pipe: RTL and testbench
===============================

Name: geo_cmd_pipe

Overview:
- Parametrised elastic command pipeline for the geometry path, placed plotter -> address generator (WIDTH=36) and address generator -> pixel writer (WIDTH=40).
- Replaces the free-running register chain that froze on a global busy signal. Each stage carries its own valid bit with valid/ready backpressure, so bubbles collapse and no command is dropped or duplicated.
- Adds an optional input skid buffer that registers in_ready, a synchronous flush, and an occupancy count for debug and FIFO-margin logic.

Parameters:
- WIDTH, 40, command word width in bits (36 for draw_cmd, 40 for pixel_cmd).
- DEPTH, 2, number of register stages, legal range 1..8.
- SKID, 1, 1 = input skid buffer with registered in_ready; 0 = combinational ready chain, no skid.
- OCC_W, $clog2(DEPTH+2), width of the occupancy output (derived; do not override).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous pipeline clear; has priority over all transfers.
- in_valid  in  1  upstream command valid.
- in_data  in  WIDTH  upstream command word.
- in_ready  out  1  pipe accepts in_data this cycle.
- out_valid  out  1  command present at the output stage.
- out_data  out  WIDTH  output command word.
- out_ready  in  1  downstream accepts (connect to the inverse of draw_busy).
- occupancy  out  OCC_W  number of commands held (stages plus skid).
- busy  out  1  occupancy != 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - all stage valids and the skid valid = 0; all data registers = 0;
  - out_valid=0, out_data=0, occupancy=0, busy=0;
  - in_ready=1 when SKID=1, and equals the chain ready when SKID=0.
- Reset applied mid-operation discards every held command. No partial command ever appears at the output after release.
- Stage i: ready_i = !valid_i || ready_{i+1}. The last stage uses ready_DEPTH = out_ready. A stage loads from its predecessor when ready_i is 1, and clears its valid when it empties.
- Transfers:
  - in transfer = in_valid && in_ready;
  - out transfer = out_valid && out_ready.
- Latency: with the pipe empty and out_ready=1, a command accepted in cycle t has out_valid=1 in cycle t+DEPTH. Throughput is 1 command/cycle when out_ready is held high.
- Bubble collapse: a stage with valid=0 always accepts, even when out_ready=0. With out_ready=0 the pipe therefore absorbs up to DEPTH commands (DEPTH+SKID in total).
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change.
- SKID=1:
  - in_ready = !skid_valid, driven straight from a register (no combinational path from out_ready).
  - An in transfer while ready_0=0 is captured into the skid. Skid valid then goes to 1 and in_ready drops the next cycle.
  - Once skid_valid=1, the skid drains into stage 0 before any new input. Order is preserved: skid contents leave before anything accepted later.
- SKID=0: in_ready = ready_0, combinational.
- Occupancy:
  - registered; occupancy_next = occupancy + in transfer - out transfer;
  - a simultaneous in and out transfer leaves it unchanged;
  - it never exceeds DEPTH+SKID; an assertion fires if it does.
- Flush:
  - In the flush cycle all valids (stages and skid) clear on the next edge and occupancy goes to 0. Data registers are not cleared.
  - Any in transfer or out transfer in the flush cycle is still counted by upstream and downstream, but the pipe discards the input.
  - in_ready stays per its normal rule during flush.
- Data registers load only on a transfer into the stage (power saving). No X may propagate to out_data while out_valid=0; out_data holds its last value instead.

Decomposition:
- Shared package geo_pkg:
  - localparams GEO_DRAW_CMD_W=36 and GEO_PIXEL_CMD_W=40;
  - typedef geo_draw_cmd_t logic[35:0] and geo_pixel_cmd_t logic[39:0];
  - constant GEO_PIPE_MAX_DEPTH=8.
- Sub-module geo_pipe_stage: one elastic register slice (valid, data, ready_in/ready_out, flush, async active-low reset), instantiated DEPTH times in a generate loop.
- The skid and occupancy logic live in geo_cmd_pipe.

Test Plan:
- Reset release, then 3 back-to-back commands 0x01,0x02,0x03 with out_ready=1, DEPTH=2 -> out_valid rises 2 cycles after the first accept; output sequence 0x01,0x02,0x03 with no gaps; occupancy peaks at 2.
- out_ready=0 with continuous input, DEPTH=2, SKID=1 -> exactly 3 commands accepted; in_ready=0 from the 4th cycle; occupancy=3; out_data is the first command and stays stable. Then out_ready=1 -> all 3 drain in order, occupancy returns to 0.
- Bubble test: send A, 2 idle cycles, then B, with out_ready=0 -> A and B sit in adjacent stages (occupancy=2); on release they appear in consecutive cycles.
- Alternating out_ready 1/0 for 20 cycles against random in_valid -> scoreboard shows no loss or duplication, and out_data is never changed while stalled.
- flush asserted with occupancy=3 while in_valid=1 -> next cycle occupancy=0 and out_valid=0; a command sent after the flush emerges DEPTH cycles later.
- reset driven low mid-stream with occupancy=2, asynchronously between edges -> out_valid, busy and occupancy go to 0 immediately. After release, in_ready=1 (SKID=1), and the SKID=0 build passes the same checks.

Source files
------------

// File: rtl/geo_pkg.sv
// Shared geometry-path types and limits used by the command pipelines
// between the plotter, address generator and pixel writer.
package geo_pkg;

    localparam int GEO_DRAW_CMD_W     = 36;
    localparam int GEO_PIXEL_CMD_W    = 40;
    localparam int GEO_PIPE_MAX_DEPTH = 8;

    typedef logic [GEO_DRAW_CMD_W-1:0]  geo_draw_cmd_t;
    typedef logic [GEO_PIXEL_CMD_W-1:0] geo_pixel_cmd_t;

endpackage

// File: rtl/geo_pipe_stage.sv
// One elastic register slice: holds a single command with its own valid bit
// and accepts whenever it is empty or its successor is taking its contents.
module geo_pipe_stage
    import geo_pkg::*;
#(
    parameter int WIDTH = GEO_PIXEL_CMD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             ready_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic             load;

    assign ready_o = !valid_q || ready_i;
    assign load    = ready_o && valid_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ready_o) begin
            valid_d = valid_i;
        end
    end

    // Data only moves on a real transfer so an empty slice keeps its last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                data_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/geo_cmd_pipe.sv
// Elastic valid/ready command pipeline of DEPTH slices with an optional input
// skid buffer (registered in_ready), synchronous flush and occupancy count.
module geo_cmd_pipe
    import geo_pkg::*;
#(
    parameter int WIDTH = GEO_PIXEL_CMD_W,
    parameter int DEPTH = 2,
    parameter int SKID  = 1,
    parameter int OCC_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy,
    output logic             busy
);

    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH + SKID);

    logic             stage_valid [DEPTH+1];
    logic [WIDTH-1:0] stage_data  [DEPTH+1];
    logic             stage_ready [DEPTH+1];

    logic             head_valid;
    logic [WIDTH-1:0] head_data;
    logic             in_xfer;
    logic             out_xfer;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    assign stage_valid[0]     = head_valid;
    assign stage_data[0]      = head_data;
    assign stage_ready[DEPTH] = out_ready;
    assign out_valid          = stage_valid[DEPTH];
    assign out_data           = stage_data[DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        geo_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .valid_i (stage_valid[i]),
            .data_i  (stage_data[i]),
            .ready_i (stage_ready[i+1]),
            .valid_o (stage_valid[i+1]),
            .data_o  (stage_data[i+1]),
            .ready_o (stage_ready[i])
        );
    end

    if (SKID != 0) begin : g_skid
        logic             skid_valid_q;
        logic             skid_valid_d;
        logic [WIDTH-1:0] skid_data_q;
        logic             skid_load;

        // A held skid word always goes ahead of new input, preserving order.
        assign in_ready   = !skid_valid_q;
        assign head_valid = skid_valid_q || in_valid;
        assign head_data  = skid_valid_q ? skid_data_q : in_data;
        assign skid_load  = in_xfer && !stage_ready[0];

        always_comb begin
            skid_valid_d = skid_valid_q;
            if (flush) begin
                skid_valid_d = 1'b0;
            end else if (skid_valid_q) begin
                skid_valid_d = !stage_ready[0];
            end else begin
                skid_valid_d = skid_load;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
            end else begin
                skid_valid_q <= skid_valid_d;
                if (skid_load) begin
                    skid_data_q <= in_data;
                end
            end
        end
    end else begin : g_noskid
        assign in_ready   = stage_ready[0];
        assign head_valid = in_valid;
        assign head_data  = in_data;
    end

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
    assign busy      = (occ_q != '0);

    occ_bound_a: assert property (@(posedge clk) disable iff (!reset) occ_q <= OCC_MAX);

endmodule

// File: tb/tb_geo_cmd_pipe.sv
// Randomised and directed bench for geo_cmd_pipe: a SKID=1 and a SKID=0 build
// share one stimulus stream and are checked in turn against a queue model.
module tb_geo_cmd_pipe;

    localparam int W  = 36;
    localparam int D  = 2;
    localparam int OW = $clog2(D + 2);

    typedef struct {
        logic [W-1:0] data;
        int           acc;
    } cmd_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          inValid = 1'b0;
    logic [W-1:0]  inData = '0;
    logic          outReady = 1'b0;

    logic          skInReady, skOutValid, skBusy;
    logic [W-1:0]  skOutData;
    logic [OW-1:0] skOcc;
    logic          nsInReady, nsOutValid, nsBusy;
    logic [W-1:0]  nsOutData;
    logic [OW-1:0] nsOcc;

    logic          selNoSkid = 1'b0;
    logic          obsInReady, obsOutValid, obsBusy;
    logic [W-1:0]  obsOutData;
    logic [OW-1:0] obsOcc;

    cmd_t          mq[$];
    int            cyc = 0;
    int            lastPop = -100;
    int            checks = 0;
    int            errors = 0;
    bit            stallPrev = 0;
    logic [W-1:0]  stallData = '0;

    always #5 clk = ~clk;

    geo_cmd_pipe #(.WIDTH(W), .DEPTH(D), .SKID(1)) u_dut_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (inValid),
        .in_data   (inData),
        .in_ready  (skInReady),
        .out_valid (skOutValid),
        .out_data  (skOutData),
        .out_ready (outReady),
        .occupancy (skOcc),
        .busy      (skBusy)
    );

    geo_cmd_pipe #(.WIDTH(W), .DEPTH(D), .SKID(0)) u_dut_noskid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (inValid),
        .in_data   (inData),
        .in_ready  (nsInReady),
        .out_valid (nsOutValid),
        .out_data  (nsOutData),
        .out_ready (outReady),
        .occupancy (nsOcc),
        .busy      (nsBusy)
    );

    assign obsInReady  = selNoSkid ? nsInReady  : skInReady;
    assign obsOutValid = selNoSkid ? nsOutValid : skOutValid;
    assign obsOutData  = selNoSkid ? nsOutData  : skOutData;
    assign obsOcc      = selNoSkid ? nsOcc      : skOcc;
    assign obsBusy     = selNoSkid ? nsBusy     : skBusy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (skid=%0d cyc=%0d)", tag, obs, exp, !selNoSkid, cyc);
        end
    endtask

    // A skid build refuses input only when DEPTH+1 commands are held; a plain
    // build refuses only when every slice is full and downstream is stalled.
    function automatic bit expInReady();
        if (!selNoSkid) return (mq.size() < D + 1);
        return !(mq.size() == D && !outReady);
    endfunction

    // The head command is visible DEPTH cycles after acceptance, and never
    // sooner than the cycle after its predecessor left.
    function automatic bit expOutValid();
        int elig;
        if (mq.size() == 0) return 1'b0;
        elig = mq[0].acc + D;
        if (lastPop + 1 > elig) elig = lastPop + 1;
        return (cyc >= elig);
    endfunction

    task automatic checkOutput();
        bit ev;
        bit er;
        ev = expOutValid();
        er = expInReady();
        chk("in_ready", {63'd0, obsInReady}, {63'd0, er});
        chk("out_valid", {63'd0, obsOutValid}, {63'd0, ev});
        if (ev) chk("out_data", 64'(obsOutData), 64'(mq[0].data));
        if (stallPrev) chk("stall_hold", 64'(obsOutData), 64'(stallData));
        chk("occupancy", 64'(obsOcc), 64'(mq.size()));
        chk("busy", {63'd0, obsBusy}, {63'd0, mq.size() != 0});

        stallPrev = ev && !outReady && !flush;
        if (ev) stallData = mq[0].data;
        if (flush) begin
            mq.delete();
        end else begin
            if (ev && outReady) begin
                void'(mq.pop_front());
                lastPop = cyc;
            end
            if (inValid && er) mq.push_back('{data: inData, acc: cyc});
        end
        cyc++;
    endtask

    task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl);
        inValid  = v;
        inData   = d;
        outReady = ordy;
        flush    = fl;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    // Drops reset between clock edges and checks the outputs clear at once.
    task automatic doReset();
        #2;
        inValid  = 1'b0;
        outReady = 1'b0;
        flush    = 1'b0;
        reset    = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, obsOutValid}, 64'd0);
        chk("rst_busy", {63'd0, obsBusy}, 64'd0);
        chk("rst_occupancy", 64'(obsOcc), 64'd0);
        chk("rst_out_data", 64'(obsOutData), 64'd0);
        chk("rst_in_ready", {63'd0, obsInReady}, 64'd1);
        mq.delete();
        lastPop   = -100;
        stallPrev = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [W-1:0] rndData();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
    endfunction

    task automatic runSuite();
        doReset();

        // Back-to-back commands with downstream always ready.
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, W'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Continuous input against a stalled output, then drain.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, W'(16 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Bubble collapse: A, two idle cycles, B, all while stalled.
        applyStimulus(1'b1, W'('hA), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, W'('hB), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Alternating out_ready against random input.
        for (int i = 0; i < 20; i++) applyStimulus(1'($urandom_range(0, 1)), rndData(), (i % 2) == 0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Fill, flush with input present, then one command after the flush.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, W'('h20 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, W'('h2F), 1'b0, 1'b1);
        applyStimulus(1'b1, W'('h30), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Mid-stream asynchronous reset with two commands held.
        applyStimulus(1'b1, W'('h40), 1'b0, 1'b0);
        applyStimulus(1'b1, W'('h41), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, W'('h50), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Long random run with occasional flushes.
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), rndData(),
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        $display("[TB] geo_cmd_pipe bench, DEPTH=%0d WIDTH=%0d", D, W);
        selNoSkid = 1'b0;
        runSuite();
        selNoSkid = 1'b1;
        runSuite();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
